// File: rtl/pbkdf2_ctrl.sv
// pbkdf2_ctrl: computes one PBKDF2-HMAC-SHA256 output block T_blk by
// driving a single hmac_sha256 core for iter chained invocations.
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   pwd_i, salt_i, salt_len_i       password / salt (left aligned) / salt bytes
//   blk_idx_i, iter_i               block index (BE), iteration count
//   v_i / r_o                       request handshake
//   dk_o, err_o, v_o / r_i          result block, illegal-salt flag, handshake
//   hmac_key_o, hmac_msg_o,
//   hmac_len_o, hmac_v_o / hmac_r_i core request (key, message, length)
//   hmac_prf_i, hmac_v_i / hmac_r_o core response
module pbkdf2_ctrl #(
    parameter int ITER_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [511:0]      pwd_i,
    input  logic [511:0]      salt_i,
    input  logic [5:0]        salt_len_i,
    input  logic [31:0]       blk_idx_i,
    input  logic [ITER_W-1:0] iter_i,
    input  logic              v_i,
    output logic              r_o,
    output logic [255:0]      dk_o,
    output logic              err_o,
    output logic              v_o,
    input  logic              r_i,
    output logic [511:0]      hmac_key_o,
    output logic [511:0]      hmac_msg_o,
    output logic [5:0]        hmac_len_o,
    output logic              hmac_v_o,
    input  logic              hmac_r_i,
    input  logic [255:0]      hmac_prf_i,
    input  logic              hmac_v_i,
    output logic              hmac_r_o
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [ITER_W-1:0] ONE = ITER_W'(1);

    state_t            state;
    logic [511:0]      salt_q;
    logic [5:0]        salt_len_q;
    logic [31:0]       blk_idx_q;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] cnt;
    logic [255:0]      u;
    logic [511:0]      first_msg;

    logic [511:0]      salt_mask;
    logic [511:0]      idx_word;

    // Keep only the first salt_len bytes of the incoming salt.
    assign salt_mask = ~({512{1'b1}} >> {salt_len_i, 3'b000});

    // INT_32BE(blk_idx) placed right after the last salt byte.
    assign idx_word = {blk_idx_q, 480'b0} >> {salt_len_q, 3'b000};

    // First iteration hashes salt||idx; later ones chain the previous U.
    assign hmac_msg_o = (cnt == ONE) ? first_msg : {u, 256'b0};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            r_o        <= 1'b1;
            v_o        <= 1'b0;
            hmac_v_o   <= 1'b0;
            hmac_r_o   <= 1'b0;
            err_o      <= 1'b0;
            dk_o       <= '0;
            hmac_key_o <= '0;
            hmac_len_o <= '0;
            salt_q     <= '0;
            salt_len_q <= '0;
            blk_idx_q  <= '0;
            iter_q     <= '0;
            cnt        <= '0;
            u          <= '0;
            first_msg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (v_i) begin
                        hmac_key_o <= pwd_i;
                        salt_q     <= salt_i & salt_mask;
                        salt_len_q <= salt_len_i;
                        blk_idx_q  <= blk_idx_i;
                        iter_q     <= (iter_i == '0) ? ONE : iter_i;
                        dk_o       <= '0;
                        cnt        <= ONE;
                        r_o        <= 1'b0;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (salt_len_q > 6'd51) begin
                        err_o <= 1'b1;
                        dk_o  <= '0;
                        v_o   <= 1'b1;
                        state <= DONE;
                    end else begin
                        err_o      <= 1'b0;
                        first_msg  <= salt_q | idx_word;
                        hmac_len_o <= salt_len_q + 6'd4;
                        hmac_v_o   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hmac_r_i) begin
                        hmac_v_o <= 1'b0;
                        hmac_r_o <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (hmac_v_i) begin
                        u        <= hmac_prf_i;
                        dk_o     <= dk_o ^ hmac_prf_i;
                        hmac_r_o <= 1'b0;
                        // Compare before incrementing so cnt never wraps.
                        if (cnt == iter_q) begin
                            v_o   <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt        <= cnt + ONE;
                            hmac_len_o <= 6'd32;
                            hmac_v_o   <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (r_i) begin
                        v_o   <= 1'b0;
                        r_o   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    v_o      <= 1'b0;
                    hmac_v_o <= 1'b0;
                    hmac_r_o <= 1'b0;
                    r_o      <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pbkdf2_ctrl.md
# pbkdf2_ctrl

Iteration controller that computes one 256-bit PBKDF2-HMAC-SHA256 output block by driving a single `hmac_sha256` core. It builds the first HMAC message from `salt || INT_32BE(blk_idx)` and chains each PRF output back in as the next message. It XOR-accumulates every U_j and returns T_blk after `iter` HMAC invocations. It sits between the top-level request interface and the HMAC core, and owns the core's input mux and handshake.

## Interface

- `ITER_W`, default 32: width of the iteration-count input and counter.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `pwd_i`  in  512  password, left aligned; bytes beyond the password are zero.
- `salt_i`  in  512  salt, left aligned.
- `salt_len_i`  in  6  salt length in bytes; legal range 0..51.
- `blk_idx_i`  in  32  PBKDF2 block index, big-endian.
- `iter_i`  in  ITER_W  iteration count c.
- `v_i` / `r_o`  in / out  1  request valid / ready.
- `dk_o`  out  256  T_blk result.
- `err_o`  out  1  result flag: salt length was illegal.
- `v_o` / `r_i`  out / in  1  result valid / ready.
- `hmac_key_o`  out  512  key to the core; always the latched password.
- `hmac_msg_o`  out  512  left-aligned message to the core.
- `hmac_len_o`  out  6  message length in bytes.
- `hmac_v_o` / `hmac_r_i`  out / in  1  core input valid / ready.
- `hmac_prf_i`  in  256  core output.
- `hmac_v_i` / `hmac_r_o`  in / out  1  core output valid / ready.

## Operation

- **Request acceptance.** A request is accepted on `v_i & r_o`. On acceptance the block latches the following:
  - `pwd`, `blk_idx`, `salt_len`.
  - `salt`, with bytes at index ≥ `salt_len` masked to zero.
  - `iter`; 0 is latched as 1.
  - It also sets `acc <= 0`, `cnt <= 1`.
- **States.**
  - IDLE: `r_o = 1`. On accept, go to CHECK.
  - CHECK: 1 cycle. If `salt_len > 51`, set `err <= 1`, `acc <= 0`, and go to DONE. Otherwise set `err <= 0` and go to ISSUE.
  - ISSUE: `hmac_v_o = 1`. On `hmac_r_i`, go to WAIT.
  - WAIT: `hmac_r_o = 1`. On `hmac_v_i`:
    - `u <= hmac_prf_i`, `acc <= acc ^ hmac_prf_i`.
    - If `cnt == iter`, go to DONE. Otherwise `cnt <= cnt + 1` and go to ISSUE.
  - DONE: `v_o = 1`. On `r_i`, go to IDLE.
- **Message selection.**
  - When `cnt == 1`: `hmac_msg_o = salt | ({blk_idx, 480'b0} >> (8*salt_len))` and `hmac_len_o = salt_len + 4`.
  - Otherwise: `hmac_msg_o = {u, 256'b0}` and `hmac_len_o = 32`.
- **Held outputs.**
  - `hmac_key_o`, `hmac_msg_o` and `hmac_len_o` are registered/derived from latched state only. They are stable for the whole of ISSUE and WAIT.
  - `hmac_v_o` is asserted only in ISSUE and is never high in WAIT. The core muxes its second pass on its own valid input.
- **Result outputs.** `dk_o = acc` and `err_o = err`. Both are stable while `v_o` is high.
- **Counter arithmetic.** `cnt` is ITER_W bits. The comparison `cnt == iter` happens before the increment, so `cnt` never wraps; `iter = 2^ITER_W - 1` is legal.
- **Ignored inputs.**
  - `v_i` outside IDLE is ignored, with no effect on latched state.
  - `hmac_v_i` outside WAIT is ignored.
- **Reset.** Asynchronous assertion of `rst_ni` at any time, including mid-iteration, returns the block to IDLE and clears `acc`, `u`, `cnt`, `err`. The top level resets the HMAC core from the same source in the same cycle.

## Timing

- **Reset values.** `r_o = 1`, `v_o = 0`, `err_o = 0`, `dk_o = 0`, `hmac_v_o = 0`, `hmac_r_o = 0`, `hmac_key_o = 0`, `hmac_msg_o = 0`, `hmac_len_o = 0`.
- **Accept to first issue.** Accept in cycle t, CHECK in t+1, `hmac_v_o` high in t+2.
- **Per iteration.**
  - The cycle after `hmac_v_i` in WAIT is either ISSUE of the next iteration or DONE.
  - Iteration cost is (ISSUE cycles until `hmac_r_i`) + (core latency).
- **Result.** `v_o` rises the cycle after the final `hmac_v_i`. `v_o` is held with `dk_o` stable until `r_i`; there is no timeout.
- **Back-to-back requests.** `r_o` returns the cycle after the `v_o & r_i` handshake. There is no input/output overlap; one request is in flight at a time.
- **Error path.** With `err_o = 1`, `v_o` rises at t+2 and the core sees no traffic.

## Test plan

- **c = 1.** P = "password", S = "salt" (len 4), blk 1, iter 1 -> `dk_o = 120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b`, `err_o = 0`, exactly 1 core handshake.
- **c = 2.** Same P and S, iter 2 -> `dk_o = ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43`. The second issue has `hmac_len_o = 32` and `hmac_msg_o[511:256] = U1`.
- **c = 4096 with backpressure.** Same P and S, iter 4096, with `hmac_r_i` randomly low -> `dk_o = c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a`, exactly 4096 core handshakes, and message stable while `hmac_v_o` is high.
- **Zero count and result stalls.** iter 0 -> same result as c = 1. Hold `r_i` low 10 cycles after `v_o` -> `v_o` and `dk_o` stay constant; `r_o` goes high 1 cycle after release.
- **Illegal salt length.** `salt_len_i = 52` -> `v_o` at accept+2, `err_o = 1`, `dk_o = 0`, `hmac_v_o` never asserted. A following legal request returns `err_o = 0`.
- **Reset mid-run.** Deassert `rst_ni` asynchronously during WAIT of iteration 3 -> outputs reach their reset values immediately. A new c = 1 request afterwards yields the c = 1 vector.
